// File: rtl/seg_scan_display_ctrl_if.sv
// Display-side bundle of the scanning 7-segment driver: frame data inputs and
// board-facing scan outputs.
interface seg_scan_display_ctrl_if #(
   parameter int DIGITS = 8
);
   localparam int WW = $clog2(DIGITS);

   logic [4*DIGITS-1:0] data;
   logic [DIGITS-1:0]   dp;
   logic [DIGITS-1:0]   blink;
   logic                lz_en;
   logic [3:0]          bright;
   logic [WW-1:0]       which;
   logic [DIGITS-1:0]   an;
   logic [7:0]          seg;
   logic                frame_done;

   modport master (
      output data, dp, blink, lz_en, bright,
      input  which, an, seg, frame_done
   );

   modport slave (
      input  data, dp, blink, lz_en, bright,
      output which, an, seg, frame_done
   );
endinterface

// File: rtl/seg_scan_display_ctrl.sv
// Multiplexed common-anode 7-segment scanner with per-digit dp/blink, leading-zero
// blanking, 16-level PWM brightness, ghost guard and frame-synchronous input capture.
module seg_scan_display_ctrl #(
   parameter int DIGITS     = 8,
   parameter int DIV_BITS   = 11,
   parameter int GUARD      = 2,
   parameter int BLINK_BITS = 6
) (
   input  logic                   clk,
   input  logic                   rst,
   seg_scan_display_ctrl_if.slave disp_io
);
   localparam int WW = $clog2(DIGITS);

   logic [DIV_BITS-1:0]   cnt_q, cnt_d;
   logic [WW-1:0]         which_q, which_d;
   logic [BLINK_BITS-1:0] frame_cnt_q, frame_cnt_d;
   logic [4*DIGITS-1:0]   data_sh_q, data_sh_d;
   logic [DIGITS-1:0]     dp_sh_q, dp_sh_d;
   logic [DIGITS-1:0]     blink_sh_q, blink_sh_d;
   logic                  lz_en_sh_q, lz_en_sh_d;
   logic [3:0]            bright_sh_q, bright_sh_d;
   logic [7:0]            seg_q, seg_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  frame_done_q, frame_done_d;

   logic                  slot_end_s, frame_wrap_s;
   logic [3:0]            nib_s;
   logic                  dp_bit_s, blink_bit_s, zero_run_s, lz_hit_s, blank_s, lit_s;

   function automatic logic [6:0] hex_font(input logic [3:0] nib);
      logic [6:0] f;
      case (nib)
         4'h0:    f = 7'b0000001;
         4'h1:    f = 7'b1001111;
         4'h2:    f = 7'b0010010;
         4'h3:    f = 7'b0000110;
         4'h4:    f = 7'b1001100;
         4'h5:    f = 7'b0100100;
         4'h6:    f = 7'b0100000;
         4'h7:    f = 7'b0001111;
         4'h8:    f = 7'b0000000;
         4'h9:    f = 7'b0000100;
         4'hA:    f = 7'b0001000;
         4'hB:    f = 7'b1100000;
         4'hC:    f = 7'b0110001;
         4'hD:    f = 7'b1000010;
         4'hE:    f = 7'b0110000;
         4'hF:    f = 7'b0111000;
         default: f = 7'b1111111;
      endcase
      return f;
   endfunction

   // State and registered outputs; async reset blanks the display at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q        <= '0;
         which_q      <= '0;
         frame_cnt_q  <= '0;
         data_sh_q    <= '0;
         dp_sh_q      <= '0;
         blink_sh_q   <= '0;
         lz_en_sh_q   <= 1'b0;
         bright_sh_q  <= 4'h0;
         seg_q        <= 8'hFF;
         an_q         <= '1;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         which_q      <= which_d;
         frame_cnt_q  <= frame_cnt_d;
         data_sh_q    <= data_sh_d;
         dp_sh_q      <= dp_sh_d;
         blink_sh_q   <= blink_sh_d;
         lz_en_sh_q   <= lz_en_sh_d;
         bright_sh_q  <= bright_sh_d;
         seg_q        <= seg_d;
         an_q         <= an_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Slot/digit advance; inputs are sampled only as the scan wraps so a frame never tears.
   always_comb begin
      cnt_d        = cnt_q + DIV_BITS'(1'b1);
      slot_end_s   = (cnt_q == {DIV_BITS{1'b1}});
      frame_wrap_s = slot_end_s && (which_q == WW'(DIGITS - 1));
      which_d      = which_q;
      frame_cnt_d  = frame_cnt_q;
      data_sh_d    = data_sh_q;
      dp_sh_d      = dp_sh_q;
      blink_sh_d   = blink_sh_q;
      lz_en_sh_d   = lz_en_sh_q;
      bright_sh_d  = bright_sh_q;
      frame_done_d = 1'b0;
      if (frame_wrap_s) begin
         which_d      = '0;
         frame_cnt_d  = frame_cnt_q + BLINK_BITS'(1'b1);
         data_sh_d    = disp_io.data;
         dp_sh_d      = disp_io.dp;
         blink_sh_d   = disp_io.blink;
         lz_en_sh_d   = disp_io.lz_en;
         bright_sh_d  = disp_io.bright;
         frame_done_d = 1'b1;
      end else if (slot_end_s) begin
         which_d = which_q + WW'(1'b1);
      end else begin
         which_d = which_q;
      end
   end

   // Current digit's nibble/flags; zero_run tracks "all digits left of and including i are zero".
   always_comb begin
      nib_s       = 4'h0;
      dp_bit_s    = 1'b0;
      blink_bit_s = 1'b0;
      zero_run_s  = 1'b1;
      lz_hit_s    = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         zero_run_s = zero_run_s && (data_sh_q[4*(DIGITS-i)-1 -: 4] == 4'h0);
         if (WW'(i) == which_q) begin
            nib_s       = data_sh_q[4*(DIGITS-i)-1 -: 4];
            dp_bit_s    = dp_sh_q[DIGITS-1-i];
            blink_bit_s = blink_sh_q[DIGITS-1-i];
            lz_hit_s    = zero_run_s && (i != DIGITS - 1);
         end else begin
            lz_hit_s = lz_hit_s;
         end
      end
      blank_s = (blink_bit_s && frame_cnt_q[BLINK_BITS-1]) || (lz_en_sh_q && lz_hit_s);
      lit_s   = (cnt_q >= DIV_BITS'(GUARD)) && (cnt_q[DIV_BITS-1 -: 4] <= bright_sh_q) && !blank_s;
      if (lit_s) begin
         an_d  = ~(DIGITS'(1'b1) << which_q);
         seg_d = {hex_font(nib_s), ~dp_bit_s};
      end else begin
         an_d  = '1;
         seg_d = 8'hFF;
      end
   end

   assign disp_io.which      = which_q;
   assign disp_io.an         = an_q;
   assign disp_io.seg        = seg_q;
   assign disp_io.frame_done = frame_done_q;
endmodule

// File: tb/tb_seg_scan_display_ctrl.sv
// Directed bench for seg_scan_display_ctrl (4 digits, 64-clock slots): expected
// per-digit slot behaviour is queued before each frame and compared as it scans.
module tb_seg_scan_display_ctrl;
   localparam int SLOT  = 64;
   localparam int FRAME = 4 * SLOT;

   typedef struct {
      logic [7:0] seg;
      logic [3:0] an;
      int         first;
      int         last;
   } exp_t;

   logic  clk = 1'b0;
   logic  rst;
   int    cyc;
   int    n_checks = 0;
   int    n_pass   = 0;
   int    n_fail   = 0;
   string phase    = "init";
   exp_t  exp_q[$];
   int    f;

   seg_scan_display_ctrl_if #(.DIGITS(4)) dif ();

   seg_scan_display_ctrl #(
      .DIGITS(4), .DIV_BITS(6), .GUARD(2), .BLINK_BITS(2)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .disp_io (dif)
   );

   always #5 clk = ~clk;

   // Bench-side time base: clocks since reset release, frames start every 256.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp_v);
      end
   endtask

   task automatic push_lit(input int d, input logic [7:0] seg, input int first, input int last);
      logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      exp_q.push_back('{seg, an_tab[d], first, last});
   endtask

   task automatic push_dark();
      exp_q.push_back('{8'hFF, 4'hF, 0, 0});
   endtask

   task automatic wait_frame(output int fidx);
      for (int i = 0; i < FRAME + 40; i++) begin
         @(negedge clk);
         if (dif.frame_done === 1'b1) break;
      end
      chk("fd_seen", {31'd0, dif.frame_done}, 32'd1);
      chk("fd_period", cyc % FRAME, 32'd0);
      fidx = cyc / FRAME;
   endtask

   // Observe one whole frame starting from a frame_done cycle, then score each digit slot.
   task automatic run_frame(input int chg_at, input logic [15:0] chg_data);
      logic [7:0] s_seg [4];
      logic [3:0] s_an  [4];
      int         first [4];
      int         last  [4];
      int         nlit  [4];
      bit         clean [4];
      bit         wh_ok [4];
      bit         fd_ok;
      logic [1:0] prev_which;
      exp_t       e;
      for (int d = 0; d < 4; d++) begin
         s_seg[d] = 8'hFF; s_an[d] = 4'hF; first[d] = 0; last[d] = 0;
         nlit[d] = 0; clean[d] = 1'b1; wh_ok[d] = 1'b1;
      end
      fd_ok      = 1'b1;
      prev_which = dif.which;
      for (int k = 1; k <= FRAME; k++) begin
         int d, sc;
         @(negedge clk);
         if (k == chg_at) dif.data = chg_data;
         d  = (k - 1) / SLOT;
         sc = (k - 1) % SLOT + 1;
         if (prev_which !== 2'(d)) wh_ok[d] = 1'b0;
         if (dif.an !== 4'hF) begin
            if (nlit[d] == 0) begin
               first[d] = sc; s_seg[d] = dif.seg; s_an[d] = dif.an;
            end else if (dif.seg !== s_seg[d] || dif.an !== s_an[d] || sc != last[d] + 1) begin
               clean[d] = 1'b0;
            end
            last[d] = sc;
            nlit[d]++;
         end else if (dif.seg !== 8'hFF) begin
            clean[d] = 1'b0;
         end
         if ((dif.frame_done === 1'b1) != (k == FRAME)) fd_ok = 1'b0;
         prev_which = dif.which;
      end
      chk("fd_once", {31'd0, fd_ok}, 32'd1);
      for (int d = 0; d < 4; d++) begin
         if (exp_q.size() == 0) begin
            chk($sformatf("d%0d_sb_empty", d), 32'd0, 32'd1);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("d%0d_seg", d), {24'd0, s_seg[d]}, {24'd0, e.seg});
            chk($sformatf("d%0d_an", d), {28'd0, s_an[d]}, {28'd0, e.an});
            chk($sformatf("d%0d_first", d), first[d], e.first);
            chk($sformatf("d%0d_last", d), last[d], e.last);
            chk($sformatf("d%0d_clean", d), {31'd0, clean[d]}, 32'd1);
            chk($sformatf("d%0d_which", d), {31'd0, wh_ok[d]}, 32'd1);
         end
      end
   endtask

   initial begin
      phase     = "reset";
      rst       = 1'b1;
      dif.data  = 16'h0000;
      dif.dp    = 4'h0;
      dif.blink = 4'h0;
      dif.lz_en = 1'b0;
      dif.bright = 4'h0;
      repeat (3) @(negedge clk);
      chk("seg", {24'd0, dif.seg}, 32'hFF);
      chk("an", {28'd0, dif.an}, 32'hF);
      chk("which", {30'd0, dif.which}, 32'd0);
      chk("fd", {31'd0, dif.frame_done}, 32'd0);
      rst = 1'b0;
      // Slot 1, cycle 3: reset-time shadows show "0" at 1/16 duty, lit here.
      repeat (SLOT + 3) @(negedge clk);
      chk("pre_an", {28'd0, dif.an}, 32'b1101);
      chk("pre_seg", {24'd0, dif.seg}, 32'h03);
      chk("pre_which", {30'd0, dif.which}, 32'd1);
      rst = 1'b1;
      #1;
      chk("async_seg", {24'd0, dif.seg}, 32'hFF);
      chk("async_an", {28'd0, dif.an}, 32'hF);
      chk("async_which", {30'd0, dif.which}, 32'd0);
      dif.data   = 16'h12AF;
      dif.dp     = 4'b0100;
      dif.bright = 4'hF;
      @(negedge clk);
      rst = 1'b0;

      phase = "basic";
      push_lit(0, 8'h9F, 3, 64); push_lit(1, 8'h24, 3, 64);
      push_lit(2, 8'h11, 3, 64); push_lit(3, 8'h71, 3, 64);
      wait_frame(f);
      chk("first_fd_cyc", cyc, FRAME);
      run_frame(-1, 16'h0000);

      phase = "lz_0050";
      dif.lz_en = 1'b1; dif.data = 16'h0050; dif.dp = 4'h0;
      push_dark(); push_dark(); push_lit(2, 8'h49, 3, 64); push_lit(3, 8'h03, 3, 64);
      wait_frame(f);
      run_frame(-1, 16'h0000);

      phase = "lz_zero";
      dif.data = 16'h0000; dif.dp = 4'hF;
      push_dark(); push_dark(); push_dark(); push_lit(3, 8'h02, 3, 64);
      wait_frame(f);
      run_frame(-1, 16'h0000);

      phase = "bright0";
      dif.lz_en = 1'b0; dif.data = 16'h12AF; dif.dp = 4'h0; dif.bright = 4'h0;
      push_lit(0, 8'h9F, 3, 4); push_lit(1, 8'h25, 3, 4);
      push_lit(2, 8'h11, 3, 4); push_lit(3, 8'h71, 3, 4);
      wait_frame(f);
      run_frame(-1, 16'h0000);

      phase = "bright7";
      dif.bright = 4'h7;
      push_lit(0, 8'h9F, 3, 32); push_lit(1, 8'h25, 3, 32);
      push_lit(2, 8'h11, 3, 32); push_lit(3, 8'h71, 3, 32);
      wait_frame(f);
      run_frame(-1, 16'h0000);

      phase = "blink";
      dif.bright = 4'hF; dif.blink = 4'b0001;
      wait_frame(f);
      for (int r = 0; r < 4; r++) begin
         push_lit(0, 8'h9F, 3, 64); push_lit(1, 8'h25, 3, 64); push_lit(2, 8'h11, 3, 64);
         if (((f + r) % 4) >= 2) push_dark();
         else                    push_lit(3, 8'h71, 3, 64);
         run_frame(-1, 16'h0000);
      end

      phase = "tearfree";
      dif.blink = 4'h0; dif.data = 16'h1111;
      for (int d = 0; d < 4; d++) push_lit(d, 8'h9F, 3, 64);
      wait_frame(f);
      run_frame(100, 16'h2222);
      for (int d = 0; d < 4; d++) push_lit(d, 8'h25, 3, 64);
      run_frame(-1, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
